piso_tx_ctrl: RTL and testbench
===============================

PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 run  input  1  1 = accept new words; 0 = accept none (queued and in-flight words still complete).
REQ-005 req0_valid  input  1  requester 0 has a nibble.
REQ-006 req0_data  input  4  requester 0 nibble, MSB sent first.
REQ-007 req0_ready  output  1  requester 0 word accepted this edge when valid and ready are both 1.
REQ-008 req1_valid, req1_data, req1_ready  same widths and meanings as requester 0.
REQ-009 piso_load  output  1  drives the 4-bit PISO register's load input (1 = load, 0 = shift).
REQ-010 piso_data  output  4  parallel word to the PISO register.
REQ-011 ser_valid  output  1  PISO SerialOut carries a frame bit this cycle.
REQ-012 ser_frame  output  1  PISO SerialOut carries the frame MSB this cycle.
REQ-013 ser_src  output  1  requester id of the frame in progress; valid while ser_valid = 1.

Function
REQ-014 The block SHALL hold a one-entry buffer (hold_data[3:0], hold_src, hold_full).
REQ-015 ready: reqN_ready = run & !hold_full & grant==N; at most one ready high per cycle.
REQ-016 ready SHALL be low for any requester whose valid is low.
REQ-017 Arbitration: one valid requester gets the grant. When both are valid, grant goes to the requester not granted last. After reset, requester 0 wins the first tie.
REQ-018 On a handshake edge, hold_data and hold_src SHALL be captured, hold_full SHALL be set to 1, and last-grant SHALL be updated.
REQ-019 Phase states: IDLE, then SHIFT with ph = 0..3 (2-bit counter).
REQ-020 piso_load = 0 in SHIFT ph 0, 1 and 2; piso_load = 1 in IDLE and in SHIFT ph 3.
REQ-021 piso_data = hold_data when hold_full = 1, else 4'h0, so the idle line is 0.
REQ-022 A load edge is any edge with piso_load = 1. On a load edge with hold_full = 1, the next state SHALL be SHIFT ph 0, hold_full SHALL clear, and hold_src SHALL move to ser_src.
REQ-023 A load edge with hold_full = 0 SHALL go to IDLE.
REQ-024 In SHIFT ph 0..2, ph SHALL increment each edge.
REQ-025 ser_valid = 1 exactly in SHIFT ph 0..3, and ser_frame = 1 exactly in ph 0.
REQ-026 SerialOut then carries d3, d2, d1, d0 in ph 0..3.
REQ-027 Latency: handshake at edge E gives piso_load = 1 with the data in cycle E+1, and the MSB at SerialOut in cycle E+2.
REQ-028 Back-to-back: a word accepted in ph 0..2 SHALL follow with no gap cycle, sustaining 1 bit per clock.
REQ-029 run deasserted mid-frame SHALL finish the frame and send any held word.
REQ-030 Simultaneous load-consume and a new request at one edge: ready is 0 because hold_full = 1, so the request is accepted on a later edge; no word is ever dropped or duplicated.

Reset
REQ-031 reset_n = 0 SHALL immediately force the following, regardless of the clock:
  - state IDLE, ph = 0;
  - hold_full = 0, hold_data = 0, last-grant = 1 (so requester 0 wins the first tie);
  - piso_load = 1, piso_data = 0;
  - ser_valid = 0, ser_frame = 0, ser_src = 0.
REQ-032 A frame interrupted by reset SHALL be abandoned, not resumed. The PISO register has no reset, so SerialOut is 0 from the first clock edge after release.

Structure
REQ-033 A shared package SHALL hold:
  - the phase width (2);
  - the frame length (4);
  - IDLE_WORD = 4'h0;
  - the state enumeration IDLE/SHIFT.
REQ-034 The round-robin arbiter SHALL be a sub-module rr_arb2 (inputs: valid[1:0], last-grant; output: grant id).
REQ-035 Everything else SHALL be flat RTL in piso_tx_ctrl. The PISO register stays external.

Verification
REQ-036 The bench SHALL instantiate piso_tx_ctrl with the existing 4-bit PISO register as a reference model, and SHALL cover the scenarios REQ-037 to REQ-041.
REQ-037 Single word: req0 = 4'hA handshaken at edge E -> piso_data = A and piso_load = 1 in cycle E+1; SerialOut = 1,0,1,0 in cycles E+2..E+5; ser_frame = 1 at E+2 only; then IDLE with SerialOut = 0.
REQ-038 Contention: both requesters valid continuously, req0 = 4'h3, req1 = 4'hC -> grants go 0,1,0,1; SerialOut = 0011 1100 0011 1100 with no gaps; ser_src alternates.
REQ-039 Idle: no valid for 20 cycles -> piso_load = 1, piso_data = 0, ser_valid = 0, SerialOut = 0.
REQ-040 Reset mid-frame: reset_n low during ph 1 -> all outputs at reset values immediately; after release, no frame resumes, req0_ready = 1 once req0_valid = 1 and run = 1.
REQ-041 run gating: run = 0 with req1_valid = 1 for 10 cycles -> req1_ready stays 0; a word held before run fell is still transmitted; run back to 1 -> accepted on that edge.

Source files
------------

// File: rtl/piso_tx_ctrl_pkg.sv
// Shared types and constants for the PISO transmit controller.
package piso_tx_ctrl_pkg;

    localparam int unsigned PhWidth  = 2;
    localparam int unsigned FrameLen = 4;

    localparam logic [FrameLen-1:0] IDLE_WORD = 4'h0;
    localparam logic [PhWidth-1:0]  LastPh    = PhWidth'(FrameLen - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

endpackage

// File: rtl/piso_tx_ctrl_if.sv
// Requester handshakes plus PISO control and serial framing signals.
interface piso_tx_ctrl_if;
    import piso_tx_ctrl_pkg::*;

    logic                run;
    logic                req0_valid;
    logic [FrameLen-1:0] req0_data;
    logic                req0_ready;
    logic                req1_valid;
    logic [FrameLen-1:0] req1_data;
    logic                req1_ready;
    logic                piso_load;
    logic [FrameLen-1:0] piso_data;
    logic                ser_valid;
    logic                ser_frame;
    logic                ser_src;

    // Requester / system side.
    modport master (
        output run, req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, piso_load, piso_data, ser_valid, ser_frame, ser_src
    );

    // Controller side.
    modport slave (
        input  run, req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, piso_load, piso_data, ser_valid, ser_frame, ser_src
    );

endinterface

// File: rtl/piso_tx_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = valid[1];
        if (&valid) begin
            grant = ~last_grant;
        end
    end

endmodule

// File: rtl/piso_tx_ctrl.sv
// Feeds an external 4-bit PISO register from two requesters via a one-entry buffer,
// sustaining one bit per clock when words arrive back to back.
module piso_tx_ctrl
    import piso_tx_ctrl_pkg::*;
(
    input  logic           clock,
    input  logic           reset_n,
    piso_tx_ctrl_if.slave  bus
);

    state_e              state_q, state_d;
    logic [PhWidth-1:0]  ph_q, ph_d;
    logic [FrameLen-1:0] hold_data_q, hold_data_d;
    logic                hold_src_q, hold_src_d;
    logic                hold_full_q, hold_full_d;
    logic                last_q, last_d;
    logic                src_q, src_d;

    logic grant;
    logic ready0, ready1;
    logic handshake;
    logic load;
    logic shifting;

    rr_arb2 u_arb (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_comb begin
        ready0    = bus.run & ~hold_full_q & bus.req0_valid & ~grant;
        ready1    = bus.run & ~hold_full_q & bus.req1_valid & grant;
        handshake = ready0 | ready1;
        shifting  = (state_q == StShift);
        // The PISO reloads on the last bit so the next frame follows without a gap.
        load      = ~shifting | (ph_q == LastPh);
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        hold_data_d = hold_data_q;
        hold_src_d  = hold_src_q;
        hold_full_d = hold_full_q;
        last_d      = last_q;
        src_d       = src_q;

        if (handshake) begin
            hold_data_d = grant ? bus.req1_data : bus.req0_data;
            hold_src_d  = grant;
            hold_full_d = 1'b1;
            last_d      = grant;
        end

        // handshake requires an empty buffer, so it never collides with the consume below
        if (load) begin
            ph_d = '0;
            if (hold_full_q) begin
                state_d     = StShift;
                hold_full_d = 1'b0;
                src_d       = hold_src_q;
            end else begin
                state_d = StIdle;
            end
        end else begin
            ph_d = ph_q + PhWidth'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ph_q        <= '0;
            hold_data_q <= '0;
            hold_src_q  <= 1'b0;
            hold_full_q <= 1'b0;
            last_q      <= 1'b1;
            src_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            hold_data_q <= hold_data_d;
            hold_src_q  <= hold_src_d;
            hold_full_q <= hold_full_d;
            last_q      <= last_d;
            src_q       <= src_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.piso_load  = load;
    assign bus.piso_data  = hold_full_q ? hold_data_q : IDLE_WORD;
    assign bus.ser_valid  = shifting;
    assign bus.ser_frame  = shifting & (ph_q == '0);
    assign bus.ser_src    = shifting & src_q;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl driving a behavioural 4-bit PISO register.
module tb_piso_tx_ctrl;

    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    piso_tx_ctrl_if bus ();

    piso_tx_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // External PISO register: no reset, load or shift-left, MSB is SerialOut.
    logic [3:0] piso_q;
    logic       ser_out;
    always_ff @(posedge clock) begin
        if (bus.piso_load) piso_q <= bus.piso_data;
        else               piso_q <= {piso_q[2:0], 1'b0};
    end
    assign ser_out = piso_q[3];

    // {req0_ready, req1_ready, piso_load, piso_data, ser_valid, ser_frame, ser_src, SerialOut}
    logic [10:0] obs;
    assign obs = {bus.req0_ready, bus.req1_ready, bus.piso_load, bus.piso_data,
                  bus.ser_valid, bus.ser_frame, bus.ser_src, ser_out};

    localparam logic [10:0] IdleObs = 11'b0_0_1_0000_0_0_0_0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic run, input logic v0, input logic [3:0] d0,
                         input logic v1, input logic [3:0] d1);
        bus.run        = run;
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        repeat (3) @(negedge clock);
        #1;
        n_cmp++;
        if (obs !== IdleObs) begin
            n_err++;
            $display("FAIL reset_state: got %b want %b", obs, IdleObs);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            drive(1'b1, 1'b0, 4'h5, 1'b0, 4'h9);
            #1;
            n_cmp++;
            if (obs !== IdleObs) begin
                n_err++;
                $display("FAIL idle cyc %0d: got %b want %b", i, obs, IdleObs);
            end
        end
    endtask

    task automatic test_contention();
        logic [10:0] exp [19];
        exp = '{11'b1_0_1_0000_0_0_0_0, 11'b0_0_1_0011_0_0_0_0, 11'b0_1_0_0000_1_1_0_0,
                11'b0_0_0_1100_1_0_0_0, 11'b0_0_0_1100_1_0_0_1, 11'b0_0_1_1100_1_0_0_1,
                11'b1_0_0_0000_1_1_1_1, 11'b0_0_0_0011_1_0_1_1, 11'b0_0_0_0011_1_0_1_0,
                11'b0_0_1_0011_1_0_1_0, 11'b0_1_0_0000_1_1_0_0, 11'b0_0_0_1100_1_0_0_0,
                11'b0_0_0_1100_1_0_0_1, 11'b0_0_1_1100_1_0_0_1, 11'b0_0_0_0000_1_1_1_1,
                11'b0_0_0_0000_1_0_1_1, 11'b0_0_0_0000_1_0_1_0, 11'b0_0_1_0000_1_0_1_0,
                11'b0_0_1_0000_0_0_0_0};
        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            drive(1'b1, i < 14, 4'h3, i < 14, 4'hC);
            #1;
            n_cmp++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL contention cyc %0d: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_single();
        logic [10:0] exp [7];
        exp = '{11'b1_0_1_0000_0_0_0_0, 11'b0_0_1_1010_0_0_0_0, 11'b0_0_0_0000_1_1_0_1,
                11'b0_0_0_0000_1_0_0_0, 11'b0_0_0_0000_1_0_0_1, 11'b0_0_1_0000_1_0_0_0,
                11'b0_0_1_0000_0_0_0_0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            drive(1'b1, i < 2, 4'hA, 1'b0, 4'h0);
            #1;
            n_cmp++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL single cyc %0d: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_run_gating();
        logic [10:0] exp [18];
        exp = '{11'b0_1_1_0000_0_0_0_0, 11'b0_0_1_0101_0_0_0_0, 11'b0_0_0_0000_1_1_1_0,
                11'b0_0_0_0000_1_0_1_1, 11'b0_0_0_0000_1_0_1_0, 11'b0_0_1_0000_1_0_1_1,
                IdleObs, IdleObs, IdleObs, IdleObs, IdleObs,
                11'b0_1_1_0000_0_0_0_0, 11'b0_0_1_0101_0_0_0_0, 11'b0_0_0_0000_1_1_1_0,
                11'b0_0_0_0000_1_0_1_1, 11'b0_0_0_0000_1_0_1_0, 11'b0_0_1_0000_1_0_1_1,
                IdleObs};
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            drive((i == 0) || (i >= 11), 1'b0, 4'h0, i < 12, 4'h5);
            #1;
            n_cmp++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL run_gating cyc %0d: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] exp [4];
        exp = '{11'b1_0_1_0000_0_0_0_0, 11'b0_0_1_1010_0_0_0_0, 11'b0_0_0_0000_1_1_0_1,
                11'b0_0_0_0000_1_0_0_0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive(1'b1, i < 1, 4'hA, 1'b0, 4'h0);
            #1;
            n_cmp++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL rst_frame cyc %0d: got %b want %b", i, obs, exp[i]);
            end
        end
        // Asserted between clock edges: controller outputs must drop at once.
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs[10:1] !== IdleObs[10:1]) begin
            n_err++;
            $display("FAIL rst_async: got %b want %b", obs[10:1], IdleObs[10:1]);
        end
        repeat (2) @(negedge clock);
        #1;
        n_cmp++;
        if (obs !== IdleObs) begin
            n_err++;
            $display("FAIL rst_held: got %b want %b", obs, IdleObs);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            n_cmp++;
            if (obs !== IdleObs) begin
                n_err++;
                $display("FAIL rst_no_resume cyc %0d: got %b want %b", i, obs, IdleObs);
            end
        end
        // First tie after reset goes to requester 0.
        @(negedge clock);
        drive(1'b1, 1'b1, 4'hA, 1'b1, 4'hC);
        #1;
        n_cmp++;
        if (obs !== 11'b1_0_1_0000_0_0_0_0) begin
            n_err++;
            $display("FAIL rst_first_tie: got %b want %b", obs, 11'b1_0_1_0000_0_0_0_0);
        end
        @(negedge clock);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        #1;
        n_cmp++;
        if (obs !== 11'b0_0_1_1010_0_0_0_0) begin
            n_err++;
            $display("FAIL rst_new_word: got %b want %b", obs, 11'b0_0_1_1010_0_0_0_0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_idle();
        test_contention();
        test_single();
        test_run_gating();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
